// File: rtl/darkseq.sv
// darkseq: bus-phase sequencer between the darkriscv core and the shared
// memory bus. Each instruction runs FETCH, then optionally LOAD or STORE,
// then a single EXEC cycle in which the core is released. Every bus phase
// has an optional timeout. A timeout ends the phase with all-ones data and
// sets a sticky error.
module darkseq #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic [AW-1:0]    IADDR,
    input  logic [AW-1:0]    DADDR,
    input  logic [DW-1:0]    DATAO,
    input  logic [DW/8-1:0]  BE,
    output logic             HLT,
    output logic [2:0]       PHS,
    output logic [DW-1:0]    IDATA,
    output logic [DW-1:0]    DATAI,
    output logic             BUS_EN,
    output logic             BUS_RE,
    output logic             BUS_WE,
    output logic [AW-1:0]    BUS_ADDR,
    output logic [DW-1:0]    BUS_DATAO,
    output logic [DW/8-1:0]  BUS_BE,
    input  logic [DW-1:0]    BUS_DATAI,
    input  logic             BUS_RACK,
    input  logic             BUS_WACK,
    output logic             ERR,
    output logic [AW-1:0]    ERR_ADDR,
    input  logic             ERR_CLR,
    output logic [CNT_W-1:0] INSTRET
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STORE = 3'd3,
        ST_EXEC  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // The wait counter only has to reach TIMEOUT-1; the phase ends there.
    localparam int             WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit             TO_EN     = (TIMEOUT != 0);

    state_t             state_reg, state_next;
    logic [DW-1:0]      ir_reg, ir_next;
    logic [DW-1:0]      dr_reg, dr_next;
    logic [WCW-1:0]     wait_reg, wait_next;
    logic               err_reg, err_next;
    logic [AW-1:0]      err_addr_reg, err_addr_next;
    logic [CNT_W-1:0]   instret_reg, instret_next;

    logic               bus_en, bus_re, bus_we, hlt;
    logic [AW-1:0]      bus_addr;
    logic [DW/8-1:0]    bus_be;
    logic               wait_last;
    logic               phase_ack;
    logic               phase_to;
    logic               in_store;

    // State and datapath registers; RES wins over everything, including a
    // bus access in flight (that access is simply abandoned).
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg    <= ST_RESET;
            ir_reg       <= '0;
            dr_reg       <= '0;
            wait_reg     <= '0;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
            instret_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ir_reg       <= ir_next;
            dr_reg       <= dr_next;
            wait_reg     <= wait_next;
            err_reg      <= err_next;
            err_addr_reg <= err_addr_next;
            instret_reg  <= instret_next;
        end
    end

    // Next-state, bus strobes, wait counting and error capture.
    always_comb begin
        state_next    = state_reg;
        ir_next       = ir_reg;
        dr_next       = dr_reg;
        wait_next     = '0;
        err_next      = err_reg;
        err_addr_next = err_addr_reg;
        instret_next  = instret_reg;
        bus_en        = 1'b0;
        bus_re        = 1'b0;
        bus_we        = 1'b0;
        bus_addr      = '0;
        bus_be        = '0;
        hlt           = 1'b1;
        phase_ack     = 1'b0;
        phase_to      = 1'b0;
        wait_last     = TO_EN && (wait_reg == WAIT_LAST);

        case (state_reg)
            ST_RESET: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                bus_en   = 1'b1;
                bus_re   = 1'b1;
                bus_addr = IADDR;
                bus_be   = '1;
                if (BUS_RACK) begin
                    phase_ack = 1'b1;
                    ir_next   = BUS_DATAI;
                    case (BUS_DATAI[6:0])
                        OP_LOAD:  state_next = ST_LOAD;
                        OP_STORE: state_next = ST_STORE;
                        default:  state_next = ST_EXEC;
                    endcase
                end else if (wait_last) begin
                    // All-ones decodes as a non-memory opcode, so go straight to EXEC.
                    phase_to   = 1'b1;
                    ir_next    = '1;
                    state_next = ST_EXEC;
                end
            end
            ST_LOAD: begin
                bus_en   = 1'b1;
                bus_re   = 1'b1;
                bus_addr = DADDR;
                bus_be   = BE;
                if (BUS_RACK) begin
                    phase_ack  = 1'b1;
                    dr_next    = BUS_DATAI;
                    state_next = ST_EXEC;
                end else if (wait_last) begin
                    phase_to   = 1'b1;
                    dr_next    = '1;
                    state_next = ST_EXEC;
                end
            end
            ST_STORE: begin
                bus_en   = 1'b1;
                bus_we   = 1'b1;
                bus_addr = DADDR;
                bus_be   = BE;
                if (BUS_WACK) begin
                    phase_ack  = 1'b1;
                    state_next = ST_EXEC;
                end else if (wait_last) begin
                    phase_to   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                hlt          = 1'b0;
                instret_next = instret_reg + 1'b1;
                state_next   = ST_FETCH;
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase

        // Count unacknowledged cycles; any phase end (or non-bus state) clears it.
        if (bus_en && !phase_ack && !phase_to) begin
            wait_next = wait_reg + 1'b1;
        end

        // A clear on the same edge as a new timeout loses to the timeout, and
        // the new address is recorded because the old error was just cleared.
        if (ERR_CLR) begin
            err_next = 1'b0;
        end
        if (phase_to) begin
            err_next = 1'b1;
            if (!err_reg || ERR_CLR) begin
                err_addr_next = bus_addr;
            end
        end
    end

    assign in_store = (state_reg == ST_STORE);

    // Write data is only presented on the bus during STORE, lane by lane.
    for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
        assign BUS_DATAO[gi*8 +: 8] = in_store ? DATAO[gi*8 +: 8] : 8'h00;
    end

    assign HLT      = hlt;
    assign PHS      = state_reg;
    assign IDATA    = ir_reg;
    assign DATAI    = dr_reg;
    assign BUS_EN   = bus_en;
    assign BUS_RE   = bus_re;
    assign BUS_WE   = bus_we;
    assign BUS_ADDR = bus_addr;
    assign BUS_BE   = bus_be;
    assign ERR      = err_reg;
    assign ERR_ADDR = err_addr_reg;
    assign INSTRET  = instret_reg;

endmodule

// File: tb/tb_darkseq.sv
// tb_darkseq: drives instructions into darkseq with a cycle-accurate
// stimulus schedule derived from the phase rules, pushes the expected
// per-instruction outcome into a queue, and a negedge monitor checks the
// bus during phases and the registers at every EXEC cycle.
module tb_darkseq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 4;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    logic          clk = 1'b0;
    logic          res;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] datao;
    logic [3:0]    be;
    logic          hlt;
    logic [2:0]    phs;
    logic [DW-1:0] idata, datai;
    logic          bus_en, bus_re, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_datao;
    logic [3:0]    bus_be;
    logic [DW-1:0] bus_datai;
    logic          bus_rack, bus_wack;
    logic          err;
    logic [AW-1:0] err_addr;
    logic          err_clr;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    darkseq #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(clk), .RES(res), .IADDR(iaddr), .DADDR(daddr), .DATAO(datao), .BE(be),
        .HLT(hlt), .PHS(phs), .IDATA(idata), .DATAI(datai),
        .BUS_EN(bus_en), .BUS_RE(bus_re), .BUS_WE(bus_we), .BUS_ADDR(bus_addr),
        .BUS_DATAO(bus_datao), .BUS_BE(bus_be), .BUS_DATAI(bus_datai),
        .BUS_RACK(bus_rack), .BUS_WACK(bus_wack),
        .ERR(err), .ERR_ADDR(err_addr), .ERR_CLR(err_clr), .INSTRET(instret)
    );

    typedef struct {
        logic [31:0] ia, da, dout;
        logic [3:0]  be;
        logic [31:0] ir, dr;
        logic        err;
        logic [31:0] err_addr;
        int          instret;
        int          fc, lc, sc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference state, updated per instruction from the phase rules
    logic [31:0] ir_m, dr_m, err_addr_m;
    logic        err_m;
    int          ret_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ir_m = '0; dr_m = '0; err_m = 1'b0; err_addr_m = '0; ret_m = 0;
    endtask

    task automatic timeout_m(input logic [31:0] a);
        if (!err_m) err_addr_m = a;
        err_m = 1'b1;
    endtask

    // fw/dw: ack in cycle fw/dw of the phase (0 = first cycle); -1 = never (timeout)
    task automatic run_instr(input logic [31:0] ia, input logic [31:0] instr,
                             input logic [31:0] da, input logic [31:0] dout,
                             input logic [3:0] b, input int fw, input int dw,
                             input logic [31:0] rdata, input bit clr_first, input bit clr_last);
        exp_t e;
        int fc, dc;
        bit ld, st;
        fc = (fw < 0) ? TO : fw + 1;
        dc = (dw < 0) ? TO : dw + 1;
        ld = (fw >= 0) && (instr[6:0] == OP_LD);
        st = (fw >= 0) && (instr[6:0] == OP_ST);
        ir_m = (fw < 0) ? 32'hFFFF_FFFF : instr;
        if (ld) dr_m = (dw < 0) ? 32'hFFFF_FFFF : rdata;
        if (clr_first || clr_last) err_m = 1'b0;
        if (fw < 0) timeout_m(ia);
        if ((ld || st) && dw < 0) timeout_m(da);
        e.ia = ia; e.da = da; e.dout = dout; e.be = b;
        e.ir = ir_m; e.dr = dr_m; e.err = err_m; e.err_addr = err_addr_m;
        e.instret = ret_m;
        e.fc = fc; e.lc = ld ? dc : 0; e.sc = st ? dc : 0;
        ret_m = (ret_m + 1) % (1 << CW);
        q.push_back(e);

        iaddr = ia; daddr = da; datao = dout; be = b;
        for (int k = 0; k < fc; k++) begin
            bus_rack  = (k == fw);
            bus_datai = (k == fw) ? instr : $urandom;
            bus_wack  = 1'($urandom_range(0, 1));
            err_clr   = (k == 0 && clr_first) || (k == fc - 1 && clr_last);
            tick();
        end
        err_clr = 1'b0;
        if (ld) begin
            for (int k = 0; k < dc; k++) begin
                bus_rack  = (k == dw);
                bus_datai = (k == dw) ? rdata : $urandom;
                bus_wack  = 1'($urandom_range(0, 1));
                tick();
            end
        end
        if (st) begin
            for (int k = 0; k < dc; k++) begin
                bus_wack  = (k == dw);
                bus_rack  = 1'($urandom_range(0, 1));
                bus_datai = $urandom;
                tick();
            end
        end
        bus_rack = 1'b0;
        bus_wack = 1'b0;
        tick();  // EXEC
    endtask

    // Monitor: accumulate per-phase bus cycles, check everything at EXEC
    exp_t mon_h;
    int fcnt = 0, lcnt = 0, scnt = 0, bad = 0;
    always @(negedge clk) begin
        if (res) begin
            fcnt = 0; lcnt = 0; scnt = 0; bad = 0;
        end else if (!hlt) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL exec_unexpected: got HLT=0 expected no EXEC pending");
            end else begin
                mon_h = q.pop_front();
                $display("[TB] exec ia=%h ir=%h dr=%h err=%0d ea=%h ret=%0d", mon_h.ia, idata, datai, err, err_addr, instret);
                chk("exec_phs", 32'(phs), 32'd4);
                chk("exec_ir", idata, mon_h.ir);
                chk("exec_dr", datai, mon_h.dr);
                chk("exec_err", 32'(err), 32'(mon_h.err));
                chk("exec_err_addr", err_addr, mon_h.err_addr);
                chk("exec_instret", 32'(instret), 32'(mon_h.instret));
                chk("exec_strobes", 32'({bus_en, bus_re, bus_we}), 32'd0);
                chk("fetch_cycles", 32'(fcnt), 32'(mon_h.fc));
                chk("load_cycles", 32'(lcnt), 32'(mon_h.lc));
                chk("store_cycles", 32'(scnt), 32'(mon_h.sc));
                chk("bus_bad_cycles", 32'(bad), 32'd0);
            end
            fcnt = 0; lcnt = 0; scnt = 0; bad = 0;
        end else if (q.size() != 0) begin
            mon_h = q[0];
            case (phs)
                3'd1: begin
                    fcnt++;
                    if (!(bus_en && bus_re && !bus_we && bus_addr == mon_h.ia && bus_be == 4'hF)) bad++;
                end
                3'd2: begin
                    lcnt++;
                    if (!(bus_en && bus_re && !bus_we && bus_addr == mon_h.da && bus_be == mon_h.be)) bad++;
                end
                3'd3: begin
                    scnt++;
                    if (!(bus_en && bus_we && !bus_re && bus_addr == mon_h.da &&
                          bus_datao == mon_h.dout && bus_be == mon_h.be)) bad++;
                end
                default: bad++;
            endcase
        end
    end

    initial begin
        logic [31:0] ins;
        int cls, fw, dw;
        res = 1'b1; iaddr = '0; daddr = '0; datao = '0; be = '0;
        bus_datai = '0; bus_rack = 1'b0; bus_wack = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_phs", 32'(phs), 32'd0);
        chk("rst_hlt", 32'(hlt), 32'd1);
        chk("rst_bus_en", 32'({bus_en, bus_re, bus_we}), 32'd0);
        chk("rst_ir", idata, 32'd0);
        chk("rst_dr", datai, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        res = 1'b0;
        tick();
        chk("first_fetch_phs", 32'(phs), 32'd1);

        // Directed cases
        run_instr(32'h0, 32'h0000_0013, 32'h0, 32'h0, 4'hF, 0, 0, 32'h0, 0, 0);
        run_instr(32'h4, 32'h0000_2083, 32'h80, 32'h0, 4'hF, 0, 3, 32'hCAFE_BABE, 0, 0);
        run_instr(32'h8, 32'h0011_2023, 32'h84, 32'h1234_5678, 4'hF, 0, 2, 32'h0, 0, 0);
        run_instr(32'h100, 32'h0, 32'h0, 32'h0, 4'hF, -1, 0, 32'h0, 0, 0);
        run_instr(32'h200, 32'h0, 32'h0, 32'h0, 4'hF, -1, 0, 32'h0, 0, 0);
        run_instr(32'h300, 32'h0, 32'h0, 32'h0, 4'hF, -1, 0, 32'h0, 0, 1);
        run_instr(32'h304, 32'h0000_0013, 32'h0, 32'h0, 4'hF, 0, 0, 32'h0, 1, 0);
        run_instr(32'h308, 32'h0000_0033, 32'h0, 32'h0, 4'hF, 7, 0, 32'h0, 0, 0);
        run_instr(32'h30C, 32'h0000_2083, 32'h440, 32'h0, 4'h3, 0, -1, 32'h0, 0, 0);
        run_instr(32'h310, 32'h0011_2023, 32'h550, 32'hA5A5_5A5A, 4'hC, 1, -1, 32'h0, 1, 0);
        run_instr(32'h314, 32'h0000_2083, 32'h660, 32'h0, 4'hF, 0, 7, 32'h1357_9BDF, 0, 0);

        // Randomised instruction mix
        for (int n = 0; n < 150; n++) begin
            cls = $urandom_range(0, 2);
            ins = $urandom;
            if (cls == 1) ins[6:0] = OP_LD;
            else if (cls == 2) ins[6:0] = OP_ST;
            else while (ins[6:0] == OP_LD || ins[6:0] == OP_ST) ins = $urandom;
            fw = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 7);
            dw = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 7);
            run_instr($urandom, ins, $urandom, $urandom, 4'($urandom_range(0, 15)), fw, dw,
                      $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end
        repeat (2) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        // Reset in the 2nd cycle of a LOAD (untracked by the scoreboard)
        iaddr = 32'h700; daddr = 32'h780; be = 4'hF;
        bus_rack = 1'b1; bus_datai = 32'h0000_2083;
        tick();
        bus_rack = 1'b0; bus_datai = 32'h0;
        tick();
        res = 1'b1;
        tick();
        chk("midload_rst_phs", 32'(phs), 32'd0);
        chk("midload_rst_bus_en", 32'(bus_en), 32'd0);
        chk("midload_rst_hlt", 32'(hlt), 32'd1);
        chk("midload_rst_ir", idata, 32'd0);
        chk("midload_rst_dr", datai, 32'd0);
        chk("midload_rst_instret", 32'(instret), 32'd0);
        chk("midload_rst_err", 32'(err), 32'd0);
        res = 1'b0;
        model_reset();
        tick();
        chk("post_rst_fetch_phs", 32'(phs), 32'd1);

        // 17 zero-wait ALU instructions: counter wraps through zero
        for (int n = 0; n < 17; n++) begin
            run_instr(32'h1000 + 32'(n * 4), 32'h0000_0013, 32'h0, 32'h0, 4'hF, 0, 0, 32'h0, 0, 0);
        end
        chk("instret_wrap", 32'(instret), 32'(ret_m));
        repeat (2) tick();
        chk("queue_drained_end", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
